// File: rtl/mcycle_sequencer.sv
// T-state / M-cycle sequencer for a Z80-style core: drives fetch, PC-increment,
// writeback and address-source strobes. Define SEQ_HALT_EN to enable the HALT state.
module mcycle_sequencer #(
    parameter int MAX_MCYC = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mcyc_len,
    input  logic       wb_req,
    input  logic       mem_addr_req,
    input  logic       pc_inc_req,
    input  logic       mem_wait,
    input  logic       halt_req,
    input  logic       wake,
    output logic       m1t1,
    output logic       inc_pc,
    output logic       writeback,
    output logic       drive_addr,
    output logic [1:0] tstate,
    output logic [2:0] mcycle,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     r_state, w_state_nx;
    logic [1:0] r_tstate, w_tstate_nx;
    logic [2:0] r_mcycle, w_mcycle_nx;
    logic [2:0] r_len, w_len_nx;
    logic [2:0] w_len_eff;
    logic       w_run, w_t4, w_last, w_hold;
    logic       w_halt_go, w_wake;

    function automatic logic [2:0] clamp_len(input logic [2:0] raw);
        if (raw == 3'd0)
            return 3'd1;
        if (int'(raw) > MAX_MCYC)
            return 3'(MAX_MCYC);
        return raw;
    endfunction

`ifdef SEQ_HALT_EN
    // A pending wake at the halting instruction cancels the halt.
    assign w_halt_go = halt_req & ~wake;
    assign w_wake    = wake;
    assign halted    = (r_state == S_HALT);
`else
    logic w_unused_halt;
    assign w_unused_halt = halt_req ^ wake;
    assign w_halt_go     = 1'b0;
    assign w_wake        = 1'b0;
    assign halted        = 1'b0;
`endif

    // During M1 the length is not yet latched, so decode it live from the decoder.
    always_comb begin
        w_len_eff = (r_mcycle == 3'd0) ? clamp_len(mcyc_len) : r_len;
        w_run     = (r_state == S_RUN);
        w_t4      = (r_tstate == 2'd3);
        w_last    = (r_mcycle == (w_len_eff - 3'd1));
        w_hold    = (r_tstate == 2'd1) && mem_wait;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tstate_nx = r_tstate;
        w_mcycle_nx = r_mcycle;
        w_len_nx    = r_len;
        case (r_state)
            S_IDLE: begin
                w_state_nx  = S_RUN;
                w_tstate_nx = 2'd0;
                w_mcycle_nx = 3'd0;
            end
            S_RUN: begin
                if (!w_hold)
                    w_tstate_nx = r_tstate + 2'd1;
                if (w_t4) begin
                    if (r_mcycle == 3'd0)
                        w_len_nx = w_len_eff;
                    if (w_last) begin
                        w_mcycle_nx = 3'd0;
                        if (w_halt_go)
                            w_state_nx = S_HALT;
                    end else begin
                        w_mcycle_nx = r_mcycle + 3'd1;
                    end
                end
            end
            S_HALT: begin
                w_tstate_nx = 2'd0;
                w_mcycle_nx = 3'd0;
                if (w_wake)
                    w_state_nx = S_RUN;
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_tstate_nx = 2'd0;
                w_mcycle_nx = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_tstate <= 2'd0;
            r_mcycle <= 3'd0;
            r_len    <= 3'd1;
        end else begin
            r_state  <= w_state_nx;
            r_tstate <= w_tstate_nx;
            r_mcycle <= w_mcycle_nx;
            r_len    <= w_len_nx;
        end
    end

    // All strobes are gated by RUN, so reset and HALT force them low.
    assign tstate     = r_tstate;
    assign mcycle     = r_mcycle;
    assign m1t1       = w_run && (r_mcycle == 3'd0) && (r_tstate == 2'd0);
    assign inc_pc     = w_run && (r_tstate == 2'd1) && !mem_wait &&
                        ((r_mcycle == 3'd0) || pc_inc_req);
    assign drive_addr = w_run && (r_mcycle != 3'd0) && (r_tstate != 2'd3) && mem_addr_req;
    assign writeback  = w_run && w_t4 && wb_req;
    assign instr_done = w_run && w_t4 && w_last;

endmodule

// File: doc/mcycle_sequencer.md
MCYCLE_SEQUENCER -- requirements
Module: mcycle_sequencer

Interface
REQ-001 SHALL have parameter MAX_MCYC, default 6, meaning the maximum number of M-cycles per instruction.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port mcyc_len, input, 3, the M-cycle count of the current instruction from the decoder; sampled at M1 T4.
REQ-005 SHALL have port wb_req, input, 1, register writeback wanted in the current M-cycle.
REQ-006 SHALL have port mem_addr_req, input, 1, register pair drives the address bus in the current non-M1 M-cycle.
REQ-007 SHALL have port pc_inc_req, input, 1, operand fetch in the current non-M1 M-cycle needs a PC increment.
REQ-008 SHALL have port mem_wait, input, 1, memory not ready; sampled at T2.
REQ-009 SHALL have port halt_req, input, 1, halt at instruction end; active only with SEQ_HALT_EN.
REQ-010 SHALL have port wake, input, 1, interrupt pending; exits HALT.
REQ-011 SHALL have port m1t1, output, 1, the opcode-fetch start strobe.
REQ-012 SHALL have port inc_pc, output, 1, the PC increment strobe.
REQ-013 SHALL have port writeback, output, 1, the register file write strobe.
REQ-014 SHALL have port drive_addr, output, 1, selects the register-pair address-bus source.
REQ-015 SHALL have port tstate, output, 2, the current T-state (0=T1 to 3=T4).
REQ-016 SHALL have port mcycle, output, 3, the current M-cycle index (0=M1).
REQ-017 SHALL have port instr_done, output, 1, last T4 of the instruction.
REQ-018 SHALL have port halted, output, 1, sequencer in HALT.

Function
REQ-019 SHALL implement states IDLE, RUN and HALT; IDLE→RUN on the first clock after reset release.
REQ-020 In RUN, tstate SHALL advance by 1 per clock and wrap 3→0, except that it holds at T2 while mem_wait=1 at T2; it resumes the clock after mem_wait falls.
REQ-021 mcycle SHALL increment on the T4→T1 wrap and return to 0 after mcycle==len-1.
REQ-022 len SHALL be latched from mcyc_len at M1 T4; 0 SHALL be treated as 1, and values above MAX_MCYC SHALL be clamped to MAX_MCYC.
REQ-023 m1t1 SHALL be 1 exactly when state==RUN, mcycle==0 and tstate==0, for one clock.
REQ-024 inc_pc SHALL be 1 at T2 of M1 and at T2 of mcycle>0 when pc_inc_req=1, one clock only, and SHALL NOT be asserted during mem_wait hold cycles.
REQ-025 drive_addr SHALL be 1 during T1–T3 of mcycle>0 when mem_addr_req=1, and 0 at all times in M1.
REQ-026 writeback SHALL be 1 at T4 of any M-cycle with wb_req=1, combinational from wb_req gated by the state decode.
REQ-027 instr_done SHALL be 1 at T4 of mcycle==len-1; for len=1 this is M1 T4.
REQ-028 On instr_done with halt_req=1, the next state SHALL be HALT with tstate=0, mcycle=0 and all strobes 0, and halted=1.
REQ-029 HALT→RUN SHALL occur on the clock after wake=1; the first RUN cycle SHALL be M1 T1 (m1t1=1).
REQ-030 When halt_req and wake are both 1 at instr_done, the sequencer SHALL stay in RUN and start the next M1.
REQ-031 inc_pc, writeback and m1t1 SHALL be mutually exclusive in any cycle.

Reset
REQ-032 rst=0 SHALL force, asynchronously, state=IDLE, tstate=0, mcycle=0, len=1, and all outputs 0, including mid-instruction and during a mem_wait hold.
REQ-033 The first m1t1 after reset release SHALL occur on the 2nd rising clk edge.

Configuration
REQ-034 Macro SEQ_HALT_EN: when defined, the HALT state, halt_req and wake are functional.
REQ-035 When SEQ_HALT_EN is undefined, halt_req and wake SHALL be ignored, halted SHALL be tied to 0, and HALT SHALL be unreachable.

Verification
REQ-036 Reset release, mcyc_len=1, no requests -> m1t1 every 4 clocks, inc_pc 1 clock after each m1t1, instr_done at every T4.
REQ-037 mcyc_len=3, wb_req=1 in M3, mem_addr_req=1 in M2 -> drive_addr high for 3 clocks in M2, one writeback at M3 T4, next m1t1 12 clocks after the previous one.
REQ-038 mem_wait=1 for 5 clocks at M1 T2 -> tstate held at 1 for those 5 clocks, a single inc_pc, and the M-cycle lasting 9 clocks.
REQ-039 With SEQ_HALT_EN, halt_req at instr_done, wake 10 clocks later -> halted=1 for 10 clocks, then m1t1 on the following clock; without SEQ_HALT_EN -> no halt.
REQ-040 rst=0 pulse mid-M2 of a 3-cycle instruction -> all outputs 0 immediately, and m1t1 on the 2nd edge after release.
REQ-041 mcyc_len=0 and mcyc_len=7 -> treated as 1 and 6 M-cycles respectively.
